// File: rtl/if_stage.sv
// Instruction-fetch stage: a pre-IF request slot plus the IF register, a skid buffer
// that holds the instruction while ID stalls, and a latch for a redirect that could not issue yet.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'hbfc00000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ds_allowin,
  input  logic [32:0] br_bus,
  output logic        fs_to_ds_valid,
  output logic [63:0] fs_to_ds_bus,
  output logic        inst_sram_en,
  output logic [3:0]  inst_sram_wen,
  output logic [31:0] inst_sram_addr,
  output logic [31:0] inst_sram_wdata,
  input  logic [31:0] inst_sram_rdata
);

  logic        to_fs_valid_q, to_fs_valid_d;
  logic        fs_valid_q, fs_valid_d;
  logic [31:0] fs_pc_q, fs_pc_d;
  logic        inst_buf_valid_q, inst_buf_valid_d;
  logic [31:0] inst_buf_q, inst_buf_d;
  logic        br_pending_q, br_pending_d;
  logic [31:0] br_target_q, br_target_d;

  logic        br_taken;
  logic [31:0] br_target;
  logic [31:0] seq_pc;
  logic [31:0] nextpc;
  logic        fs_ready_go;
  logic        fs_allowin;
  logic        fetch_go;
  logic [31:0] fs_inst;

  assign br_taken  = br_bus[32];
  assign br_target = br_bus[31:0];
  assign seq_pc    = fs_pc_q + 32'd4;

  // A redirect latched during a stall outranks whatever ID is presenting now.
  assign nextpc = br_pending_q ? br_target_q :
                  br_taken     ? br_target   : seq_pc;

  assign fs_ready_go = 1'b1;
  assign fs_allowin  = !fs_valid_q || (fs_ready_go && ds_allowin);
  assign fetch_go    = to_fs_valid_q && fs_allowin;

  assign inst_sram_en    = fetch_go;
  assign inst_sram_wen   = 4'h0;
  assign inst_sram_addr  = nextpc;
  assign inst_sram_wdata = 32'h0;

  assign fs_inst        = inst_buf_valid_q ? inst_buf_q : inst_sram_rdata;
  assign fs_to_ds_valid = fs_valid_q && fs_ready_go;
  assign fs_to_ds_bus   = {fs_inst, fs_pc_q};

  always_comb begin
    to_fs_valid_d    = 1'b1;
    fs_valid_d       = fs_valid_q;
    fs_pc_d          = fs_pc_q;
    inst_buf_valid_d = inst_buf_valid_q;
    inst_buf_d       = inst_buf_q;
    br_pending_d     = br_pending_q;
    br_target_d      = br_target_q;

    if (fs_allowin) begin
      fs_valid_d = to_fs_valid_q;
    end
    if (fetch_go) begin
      fs_pc_d = nextpc;
    end

    // The SRAM output is only good for one cycle after a read, so park it once ID stalls.
    if (fs_valid_q && ds_allowin) begin
      inst_buf_valid_d = 1'b0;
    end else if (fs_valid_q && !ds_allowin && !inst_buf_valid_q) begin
      inst_buf_valid_d = 1'b1;
      inst_buf_d       = inst_sram_rdata;
    end

    // When the fetch issues this cycle nextpc has already used the target, so nothing to keep.
    if (fetch_go) begin
      br_pending_d = 1'b0;
    end else if (br_taken) begin
      br_pending_d = 1'b1;
      br_target_d  = br_target;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      to_fs_valid_q    <= 1'b0;
      fs_valid_q       <= 1'b0;
      fs_pc_q          <= RESET_PC - 32'd4;
      inst_buf_valid_q <= 1'b0;
      inst_buf_q       <= 32'h0;
      br_pending_q     <= 1'b0;
      br_target_q      <= 32'h0;
    end else begin
      to_fs_valid_q    <= to_fs_valid_d;
      fs_valid_q       <= fs_valid_d;
      fs_pc_q          <= fs_pc_d;
      inst_buf_valid_q <= inst_buf_valid_d;
      inst_buf_q       <= inst_buf_d;
      br_pending_q     <= br_pending_d;
      br_target_q      <= br_target_d;
    end
  end

endmodule
